// File: rtl/bbus_arbiter_2to1.sv
// Two-master, one-slave BBUS arbiter with round-robin grant and an ack watchdog.
// The granted master's request is mirrored to the slave; acks and rdata route back to it only.
module bbus_arbiter_2to1 #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    TIMEOUT    = 256,
  parameter logic [DATA_WIDTH-1:0] ERR_DATA   = 32'hDEAD_BEEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  m0_read_en,
  input  logic                  m0_write_en,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_read_ack,
  output logic                  m0_write_ack,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  input  logic                  m1_read_en,
  input  logic                  m1_write_en,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_read_ack,
  output logic                  m1_write_ack,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic                  s_read_en,
  output logic                  s_write_en,
  output logic [ADDR_WIDTH-1:0] s_addr,
  output logic [DATA_WIDTH-1:0] s_wdata,
  input  logic                  s_read_ack,
  input  logic                  s_write_ack,
  input  logic [DATA_WIDTH-1:0] s_rdata,
  output logic                  timeout_pulse
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_last_grant;
  logic [CNT_W-1:0]   r_wdog;

  logic                  w_m0_req;
  logic                  w_m1_req;
  logic                  w_gnt0;
  logic                  w_gnt1;
  logic                  w_granted;
  logic                  w_sel_rd;
  logic                  w_sel_wr;
  logic                  w_sel_req;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [DATA_WIDTH-1:0] w_sel_wdata;
  logic                  w_s_ack;
  logic                  w_timeout;
  logic                  w_rd_ack;
  logic                  w_wr_ack;
  logic [DATA_WIDTH-1:0] w_rdata;

  assign w_m0_req    = m0_read_en | m0_write_en;
  assign w_m1_req    = m1_read_en | m1_write_en;
  assign w_gnt0      = (r_state == GNT0);
  assign w_gnt1      = (r_state == GNT1);
  assign w_granted   = w_gnt0 | w_gnt1;
  assign w_sel_rd    = w_gnt0 ? m0_read_en  : m1_read_en;
  assign w_sel_wr    = w_gnt0 ? m0_write_en : m1_write_en;
  assign w_sel_req   = w_sel_rd | w_sel_wr;
  assign w_sel_addr  = w_gnt0 ? m0_addr  : m1_addr;
  assign w_sel_wdata = w_gnt0 ? m0_wdata : m1_wdata;
  assign w_s_ack     = s_read_ack | s_write_ack;

  // A real slave ack in the expiry cycle beats the watchdog; an abandoned request never times out.
  assign w_timeout = (TIMEOUT != 0) && w_granted && (r_wdog == CNT_W'(TIMEOUT))
                     && !w_s_ack && w_sel_req;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_state_nxt = r_state;
    s_read_en   = 1'b0;
    s_write_en  = 1'b0;
    s_addr      = '0;
    s_wdata     = '0;
    w_rd_ack    = 1'b0;
    w_wr_ack    = 1'b0;
    w_rdata     = '0;
    case (r_state)
      IDLE: begin
        if (w_m0_req && w_m1_req) w_state_nxt = r_last_grant ? GNT0 : GNT1;
        else if (w_m0_req)        w_state_nxt = GNT0;
        else if (w_m1_req)        w_state_nxt = GNT1;
      end
      GNT0, GNT1: begin
        s_read_en  = w_sel_rd & ~w_timeout;
        s_write_en = w_sel_wr & ~w_timeout;
        s_addr     = w_sel_addr;
        s_wdata    = w_sel_wdata;
        w_rd_ack   = s_read_ack  | (w_timeout & w_sel_rd);
        w_wr_ack   = s_write_ack | (w_timeout & w_sel_wr);
        if (s_read_ack)                w_rdata = s_rdata;
        else if (w_timeout && w_sel_rd) w_rdata = ERR_DATA;
        if (w_s_ack || w_timeout || !w_sel_req) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign m0_read_ack   = w_gnt0 & w_rd_ack;
  assign m0_write_ack  = w_gnt0 & w_wr_ack;
  assign m0_rdata      = w_gnt0 ? w_rdata : '0;
  assign m1_read_ack   = w_gnt1 & w_rd_ack;
  assign m1_write_ack  = w_gnt1 & w_wr_ack;
  assign m1_rdata      = w_gnt1 ? w_rdata : '0;
  assign timeout_pulse = w_timeout;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_last_grant <= 1'b1;
      r_wdog       <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_granted && (w_state_nxt == IDLE)) r_last_grant <= w_gnt1;
      r_wdog <= (w_granted && (w_state_nxt != IDLE)) ? r_wdog + 1'b1 : '0;
    end
  end

endmodule

// File: tb/tb_bbus_arbiter_2to1.sv
// Self-checking bench for bbus_arbiter_2to1: directed scenarios followed by random traffic,
// all compared cycle by cycle against a transaction-level reference model.
module tb_bbus_arbiter_2to1;

  localparam int          AW  = 32;
  localparam int          DW  = 32;
  localparam int          TO  = 8;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          m0_read_en, m0_write_en, m1_read_en, m1_write_en;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic          m0_read_ack, m0_write_ack, m1_read_ack, m1_write_ack;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          s_read_en, s_write_en;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wdata;
  logic          s_ra, s_wa;
  logic [DW-1:0] s_rdata;
  logic          timeout_pulse;

  // Master stimulus, indexed by master number.
  logic          m_rd[2];
  logic          m_wr[2];
  logic [AW-1:0] m_addr[2];
  logic [DW-1:0] m_wdata[2];

  assign m0_read_en  = m_rd[0];
  assign m0_write_en = m_wr[0];
  assign m0_addr     = m_addr[0];
  assign m0_wdata    = m_wdata[0];
  assign m1_read_en  = m_rd[1];
  assign m1_write_en = m_wr[1];
  assign m1_addr     = m_addr[1];
  assign m1_wdata    = m_wdata[1];

  always #5 clk = ~clk;

  bbus_arbiter_2to1 #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO), .ERR_DATA(ERR)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_read_en(m0_read_en), .m0_write_en(m0_write_en), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_read_ack(m0_read_ack), .m0_write_ack(m0_write_ack), .m0_rdata(m0_rdata),
    .m1_read_en(m1_read_en), .m1_write_en(m1_write_en), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_read_ack(m1_read_ack), .m1_write_ack(m1_write_ack), .m1_rdata(m1_rdata),
    .s_read_en(s_read_en), .s_write_en(s_write_en), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_read_ack(s_ra), .s_write_ack(s_wa), .s_rdata(s_rdata),
    .timeout_pulse(timeout_pulse)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: who owns the bus (-1 = nobody), who finished last, when the grant began.
  int md_owner = -1;
  int md_last  = 1;
  int md_gcyc  = 0;
  int md_cyc   = 0;

  logic          e_ra[2], e_wa[2], prev_ack[2];
  logic [31:0]   e_rdat[2];
  logic          e_sre, e_swe, e_tp;
  logic [31:0]   e_saddr, e_swd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s @cyc %0d: observed %h expected %h", tag, md_cyc, obs, exp);
    end
  endtask

  task automatic model_eval();
    bit req, ack;
    for (int x = 0; x < 2; x++) begin
      e_ra[x] = 1'b0; e_wa[x] = 1'b0; e_rdat[x] = '0;
    end
    e_sre = 1'b0; e_swe = 1'b0; e_saddr = '0; e_swd = '0; e_tp = 1'b0;
    if (md_owner >= 0) begin
      req   = m_rd[md_owner] || m_wr[md_owner];
      ack   = s_ra || s_wa;
      e_tp  = (TO > 0) && (md_cyc - md_gcyc == TO) && !ack && req;
      e_sre = m_rd[md_owner] && !e_tp;
      e_swe = m_wr[md_owner] && !e_tp;
      e_saddr = m_addr[md_owner];
      e_swd   = m_wdata[md_owner];
      e_ra[md_owner] = s_ra || (e_tp && m_rd[md_owner]);
      e_wa[md_owner] = s_wa || (e_tp && m_wr[md_owner]);
      if (s_ra)                          e_rdat[md_owner] = s_rdata;
      else if (e_tp && m_rd[md_owner])   e_rdat[md_owner] = ERR;
    end
  endtask

  task automatic model_advance();
    bit r0, r1;
    r0 = m_rd[0] || m_wr[0];
    r1 = m_rd[1] || m_wr[1];
    if (md_owner < 0) begin
      if (r0 && r1)  md_owner = (md_last == 0) ? 1 : 0;
      else if (r0)   md_owner = 0;
      else if (r1)   md_owner = 1;
      if (md_owner >= 0) md_gcyc = md_cyc + 1;
    end else if (s_ra || s_wa || e_tp || !(m_rd[md_owner] || m_wr[md_owner])) begin
      md_last  = md_owner;
      md_owner = -1;
    end
    md_cyc++;
  endtask

  task automatic check_all();
    check("m0_read_ack",   m0_read_ack,   e_ra[0]);
    check("m0_write_ack",  m0_write_ack,  e_wa[0]);
    check("m0_rdata",      m0_rdata,      e_rdat[0]);
    check("m1_read_ack",   m1_read_ack,   e_ra[1]);
    check("m1_write_ack",  m1_write_ack,  e_wa[1]);
    check("m1_rdata",      m1_rdata,      e_rdat[1]);
    check("s_read_en",     s_read_en,     e_sre);
    check("s_write_en",    s_write_en,    e_swe);
    check("s_addr",        s_addr,        e_saddr);
    check("s_wdata",       s_wdata,       e_swd);
    check("timeout_pulse", timeout_pulse, e_tp);
  endtask

  task automatic settle();
    #1;
  endtask

  // Called one time unit after inputs settle; compares, advances the model, then crosses the edge.
  task automatic tick();
    model_eval();
    check_all();
    model_advance();
    for (int x = 0; x < 2; x++) prev_ack[x] = e_ra[x] | e_wa[x];
    @(posedge clk);
    #1;
  endtask

  task automatic release_on_ack();
    for (int x = 0; x < 2; x++)
      if (prev_ack[x]) begin m_rd[x] = 1'b0; m_wr[x] = 1'b0; end
  endtask

  task automatic quiesce();
    for (int x = 0; x < 2; x++) begin m_rd[x] = 1'b0; m_wr[x] = 1'b0; end
    s_ra = 1'b0; s_wa = 1'b0;
  endtask

  initial begin
    int  grant_k, last_ack, wait_n;
    bit  hit;

    rst_n = 1'b0;
    for (int x = 0; x < 2; x++) begin
      m_rd[x] = 1'b0; m_wr[x] = 1'b0; m_addr[x] = '0; m_wdata[x] = '0; prev_ack[x] = 1'b0;
    end
    s_ra = 1'b0; s_wa = 1'b0; s_rdata = '0;

    // Reset state.
    #3;
    model_eval();
    check_all();
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    // M0 read of 0x100, slave acks two cycles after s_read_en rises.
    m_rd[0] = 1'b1; m_addr[0] = 32'h100;
    settle();
    check("req_not_yet_on_slave", s_read_en, 1'b0);
    tick();
    hit = 1'b0;
    for (int i = 0; i < 5; i++) begin
      s_ra    = (md_owner == 0) && (md_cyc - md_gcyc == 2);
      s_rdata = 32'h1234;
      settle();
      if (md_owner == 0 && md_cyc == md_gcyc) check("grant_visible", s_addr, 32'h100);
      if (s_ra) begin
        hit = 1'b1;
        check("t1_m0_read_ack", m0_read_ack, 1'b1);
        check("t1_m0_rdata",    m0_rdata,    32'h1234);
        check("t1_m1_read_ack", m1_read_ack, 1'b0);
      end
      tick();
      release_on_ack();
      s_ra = 1'b0;
      if (prev_ack[0]) begin
        settle();
        check("t1_s_read_en_after", s_read_en, 1'b0);
      end
    end
    check("t1_ack_seen", hit, 1'b1);

    // Contention from reset: grants alternate M0, M1, M0, M1 with one IDLE cycle between.
    quiesce();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    md_owner = -1; md_last = 1;
    m_wr[0] = 1'b1; m_addr[0] = 32'h200; m_wdata[0] = 32'hA0A0_0000;
    m_wr[1] = 1'b1; m_addr[1] = 32'h300; m_wdata[1] = 32'hB1B1_1111;
    grant_k = 0;
    for (int i = 0; i < 10; i++) begin
      s_wa = (md_owner >= 0);
      settle();
      if (md_owner >= 0) begin
        check("alt_grant_addr", s_addr, (grant_k % 2 == 0) ? 32'h200 : 32'h300);
        grant_k++;
      end
      tick();
    end
    check("alt_grant_count", grant_k, 5);

    // M1 holds read_en; slave acks one cycle after grant: service every 3 cycles.
    quiesce();
    m_rd[1] = 1'b1; m_addr[1] = 32'h340;
    last_ack = -1;
    for (int i = 0; i < 14; i++) begin
      s_ra    = (md_owner == 1) && (md_cyc - md_gcyc == 1);
      s_rdata = 32'h5000 + i;
      settle();
      if (m1_read_ack === 1'b1) begin
        if (last_ack >= 0) check("m1_service_period", md_cyc - last_ack, 3);
        last_ack = md_cyc;
      end
      tick();
    end

    // Watchdog: M1 read, slave silent.
    quiesce();
    @(posedge clk); #1;
    md_cyc++;
    if (md_owner >= 0) begin md_last = md_owner; md_owner = -1; end
    m_rd[1] = 1'b1; m_addr[1] = 32'h400;
    hit = 1'b0;
    for (int i = 0; i < 14; i++) begin
      settle();
      if (md_owner == 1 && md_cyc - md_gcyc == TO) begin
        hit = 1'b1;
        check("to_m1_read_ack", m1_read_ack,   1'b1);
        check("to_m1_rdata",    m1_rdata,      ERR);
        check("to_pulse",       timeout_pulse, 1'b1);
        check("to_s_read_en",   s_read_en,     1'b0);
      end
      tick();
      if (prev_ack[1]) begin
        m_rd[1] = 1'b0;
        settle();
        check("to_pulse_one_cycle", timeout_pulse, 1'b0);
        check("to_idle_after",      s_read_en,     1'b0);
      end
    end
    check("to_fired", hit, 1'b1);

    // Slave ack coincides with watchdog expiry: real data wins.
    quiesce();
    m_rd[0] = 1'b1; m_addr[0] = 32'h500;
    hit = 1'b0;
    for (int i = 0; i < 14; i++) begin
      s_ra    = (md_owner == 0) && (md_cyc - md_gcyc == TO);
      s_rdata = 32'hCAFE_F00D;
      settle();
      if (s_ra) begin
        hit = 1'b1;
        check("race_m0_rdata", m0_rdata,      32'hCAFE_F00D);
        check("race_no_pulse", timeout_pulse, 1'b0);
      end
      tick();
      release_on_ack();
      s_ra = 1'b0;
    end
    check("race_seen", hit, 1'b1);

    // M0 abandons its read mid-grant.
    quiesce();
    m_rd[0] = 1'b1; m_addr[0] = 32'h540;
    hit = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (md_owner == 0 && md_cyc - md_gcyc == 2) begin
        m_rd[0] = 1'b0;
        hit = 1'b1;
        settle();
        check("abandon_no_ack", m0_read_ack, 1'b0);
        tick();
        settle();
        check("abandon_idle", s_read_en, 1'b0);
      end else begin
        settle();
      end
      tick();
    end
    check("abandon_seen", hit, 1'b1);

    // Reset during an active M0 write; afterwards M0 wins contention.
    quiesce();
    m_wr[0] = 1'b1; m_addr[0] = 32'h600; m_wdata[0] = 32'h5555_AAAA;
    wait_n = 0;
    while (md_owner != 0 && wait_n < 6) begin
      settle();
      tick();
      wait_n++;
    end
    check("rst_grant_reached", md_owner, 0);
    settle();
    check("rst_pre_write_en", s_write_en, 1'b1);
    rst_n = 1'b0;
    #1;
    check("rst_s_write_en", s_write_en,    1'b0);
    check("rst_s_addr",     s_addr,        32'h0);
    check("rst_s_wdata",    s_wdata,       32'h0);
    check("rst_m0_wack",    m0_write_ack,  1'b0);
    check("rst_pulse",      timeout_pulse, 1'b0);
    m_wr[0] = 1'b0;
    m_rd[0] = 1'b1; m_addr[0] = 32'h700;
    m_rd[1] = 1'b1; m_addr[1] = 32'h800;
    @(posedge clk); #1;
    rst_n = 1'b1;
    md_owner = -1; md_last = 1;
    settle();
    tick();
    settle();
    check("post_rst_m0_first", s_addr, 32'h700);
    tick();
    quiesce();

    // Random traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      release_on_ack();
      for (int x = 0; x < 2; x++) begin
        if (!m_rd[x] && !m_wr[x]) begin
          if ($urandom_range(0, 99) < 30) begin
            if ($urandom_range(0, 1) == 1) m_rd[x] = 1'b1;
            else                           m_wr[x] = 1'b1;
            m_addr[x]  = $urandom;
            m_wdata[x] = $urandom;
          end
        end else if ($urandom_range(0, 99) < 3) begin
          m_rd[x] = 1'b0; m_wr[x] = 1'b0;
        end
      end
      s_ra = 1'b0; s_wa = 1'b0; s_rdata = $urandom;
      if (md_owner >= 0) begin
        if ($urandom_range(0, 99) < 30) begin
          s_ra = m_rd[md_owner];
          s_wa = m_wr[md_owner];
        end
      end else if ($urandom_range(0, 99) < 5) begin
        if ($urandom_range(0, 1) == 1) s_ra = 1'b1;
        else                           s_wa = 1'b1;
      end
      settle();
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
